pc_sequencer: RTL and testbench

Instruction fetch and program-counter sequencer for the CPU core. Each instruction is fetched from instruction memory over a request/valid handshake and latched into an instruction register. The register's opcode and condition-select fields go to the control unit. The sequencer then applies the control unit's flow-control outputs (PCpp, JMP, ret, Call) to compute the next PC. It owns the hardware return-address stack used by Call/ret.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/pc_sequencer_if.sv | 36 +++
 rtl/pc_sequencer_ret_stack.sv | 78 +++++++
 rtl/pc_sequencer.sv | 125 ++++++++++++
 tb/tb_pc_sequencer.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field geometry, sequencer states, named opcodes.
// Field positions are measured down from the instruction MSB so they track INSTR_W.
package cpu_pkg;

  localparam int OPC_W     = 5;
  localparam int A_W       = 3;
  localparam int OPC_MSB_OFS = 0;
  localparam int A_MSB_OFS   = OPC_W;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_EXEC  = 1'b1
  } seq_state_e;

  localparam logic [OPC_W-1:0] OPC_CALL = 5'b10110;
  localparam logic [OPC_W-1:0] OPC_HALT = 5'b00000;

endpackage

// File: rtl/pc_sequencer_if.sv
// Sequencer bus: instruction-memory fetch handshake plus the control-unit decode/flow signals.
// master = sequencer side, slave = memory / control-unit side.
interface pc_sequencer_if
  import cpu_pkg::*;
#(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 16
) ();

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               imem_valid;

  logic [INSTR_W-1:0] instr;
  logic [OPC_W-1:0]   OPCode;
  logic [A_W-1:0]     A;
  logic               exec;

  logic               PCpp;
  logic               JMP;
  logic               ret;
  logic               Call;
  logic [PC_W-1:0]    JADDR;

  modport master (
    output imem_req, imem_addr, instr, OPCode, A, exec,
    input  imem_data, imem_valid, PCpp, JMP, ret, Call, JADDR
  );

  modport slave (
    input  imem_req, imem_addr, instr, OPCode, A, exec,
    output imem_data, imem_valid, PCpp, JMP, ret, Call, JADDR
  );

endinterface

// File: rtl/pc_sequencer_ret_stack.sv
// Hardware return-address stack (ret_stack). With STACK_GUARD_EN the pointer saturates 0..DEPTH and
// out-of-range push/pop are dropped (empty pop reads 0); otherwise the pointer wraps modulo DEPTH.
module ret_stack #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] wdata,
  output logic [PC_W-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int AW = $clog2(DEPTH);
`ifdef STACK_GUARD_EN
  localparam int SP_W = AW + 1;
`else
  localparam int SP_W = AW;
`endif

  logic [PC_W-1:0] mem_q [DEPTH];
  logic [SP_W-1:0] sp_q, sp_d;
  logic            wr_en;
  logic [AW-1:0]   wr_idx, rd_idx;

  assign wr_idx = sp_q[AW-1:0];
  assign rd_idx = AW'(sp_q - SP_W'(1));
  assign empty  = (sp_q == '0);

`ifdef STACK_GUARD_EN
  assign full = (sp_q == SP_W'(DEPTH));
  assign top  = empty ? '0 : mem_q[rd_idx];

  always_comb begin
    sp_d  = sp_q;
    wr_en = 1'b0;
    if (push && !full) begin
      wr_en = 1'b1;
      sp_d  = sp_q + SP_W'(1);
    end else if (pop && !empty) begin
      sp_d  = sp_q - SP_W'(1);
    end
  end
`else
  // A wrapping pointer cannot tell full from empty; overflow silently overwrites the oldest entry.
  assign full = 1'b0;
  assign top  = mem_q[rd_idx];

  always_comb begin
    sp_d  = sp_q;
    wr_en = 1'b0;
    if (push) begin
      wr_en = 1'b1;
      sp_d  = sp_q + SP_W'(1);
    end else if (pop) begin
      sp_d  = sp_q - SP_W'(1);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wdata;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction fetch + program-counter sequencer: FETCH (wait for imem_valid) then one EXEC cycle
// applying ret > Call > JMP > PCpp. Macro STACK_GUARD_EN enables sticky stack overflow/underflow flags.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 16,
  parameter int DEPTH   = 8
) (
  input  logic            CLK,
  input  logic            RST,
  pc_sequencer_if.master  bus,
  output logic [PC_W-1:0] pc,
  output logic            stk_ovf,
  output logic            stk_unf
);

  seq_state_e         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc_inc;
  logic [PC_W-1:0]    stk_top;
  logic               push, pop;
  logic               stk_empty, stk_full;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: if (bus.imem_valid) state_d = ST_EXEC;
      ST_EXEC:  state_d = ST_FETCH;
      default:  state_d = ST_FETCH;
    endcase
  end

  // Wraps modulo 2^PC_W; also the return address pushed by Call.
  assign pc_inc = pc_q + PC_W'(1);

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    push    = 1'b0;
    pop     = 1'b0;
    if (state_q == ST_FETCH) begin
      if (bus.imem_valid) instr_d = bus.imem_data;
    end else begin
      if (bus.ret) begin
        pop  = 1'b1;
        pc_d = stk_top;
      end else if (bus.Call) begin
        push = 1'b1;
        pc_d = bus.JADDR;
      end else if (bus.JMP) begin
        pc_d = bus.JADDR;
      end else if (bus.PCpp) begin
        pc_d = pc_inc;
      end
    end
  end

  always_comb begin
    bus.imem_req = (state_q == ST_FETCH);
    bus.exec     = (state_q == ST_EXEC);
  end

  assign bus.imem_addr = pc_q;
  assign bus.instr     = instr_q;
  assign bus.OPCode    = instr_q[INSTR_W-1-OPC_MSB_OFS -: OPC_W];
  assign bus.A         = instr_q[INSTR_W-1-A_MSB_OFS -: A_W];
  assign pc            = pc_q;

  ret_stack #(
    .DEPTH (DEPTH),
    .PC_W  (PC_W)
  ) u_ret_stack (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .pop   (pop),
    .wdata (pc_inc),
    .top   (stk_top),
    .empty (stk_empty),
    .full  (stk_full)
  );

`ifdef STACK_GUARD_EN
  logic stk_ovf_q, stk_ovf_d;
  logic stk_unf_q, stk_unf_d;

  always_comb begin
    stk_ovf_d = stk_ovf_q | (push & stk_full);
    stk_unf_d = stk_unf_q | (pop & stk_empty);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stk_ovf_q <= 1'b0;
      stk_unf_q <= 1'b0;
    end else begin
      stk_ovf_q <= stk_ovf_d;
      stk_unf_q <= stk_unf_d;
    end
  end

  assign stk_ovf = stk_ovf_q;
  assign stk_unf = stk_unf_q;
`else
  logic unused_stk_status;
  assign unused_stk_status = stk_empty | stk_full;
  assign stk_ovf = 1'b0;
  assign stk_unf = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer against a behavioural PC/stack model; honours STACK_GUARD_EN.
module tb_pc_sequencer;
  import cpu_pkg::*;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 16;
  localparam int DEPTH   = 8;
`ifdef STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [PC_W-1:0] pc;
  logic            stk_ovf, stk_unf;

  pc_sequencer_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

  pc_sequencer #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
    .CLK     (clk),
    .RST     (rst),
    .bus     (bus),
    .pc      (pc),
    .stk_ovf (stk_ovf),
    .stk_unf (stk_unf)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: architectural PC, instruction register and a plain array stack.
  logic [PC_W-1:0]    m_pc;
  logic [INSTR_W-1:0] m_instr;
  logic [PC_W-1:0]    m_stack [DEPTH];
  bit                 m_written [DEPTH];
  int                 m_sp;
  bit                 m_ovf, m_unf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pc    = '0;
    m_instr = '0;
    m_sp    = 0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  task automatic model_exec(input bit r, input bit c, input bit j, input bit p,
                            input logic [PC_W-1:0] ja);
    logic [PC_W-1:0] ra;
    ra = m_pc + 1'b1;
    if (r) begin
      if (GUARD && m_sp == 0) begin
        m_pc  = '0;
        m_unf = 1'b1;
      end else begin
        m_sp = GUARD ? m_sp - 1 : (m_sp + DEPTH - 1) % DEPTH;
        m_pc = m_stack[m_sp % DEPTH];
      end
    end else if (c) begin
      if (GUARD && m_sp == DEPTH) begin
        m_ovf = 1'b1;
      end else begin
        m_stack[m_sp % DEPTH]   = ra;
        m_written[m_sp % DEPTH] = 1'b1;
        m_sp = GUARD ? m_sp + 1 : (m_sp + 1) % DEPTH;
      end
      m_pc = ja;
    end else if (j) begin
      m_pc = ja;
    end else if (p) begin
      m_pc = m_pc + 1'b1;
    end
  endtask

  task automatic check_fetch(input string tag);
    check({tag, "_req"},   bus.imem_req,  1);
    check({tag, "_exec"},  bus.exec,      0);
    check({tag, "_addr"},  bus.imem_addr, m_pc);
    check({tag, "_pc"},    pc,            m_pc);
    check({tag, "_instr"}, bus.instr,     m_instr);
    check({tag, "_ovf"},   stk_ovf,       m_ovf);
    check({tag, "_unf"},   stk_unf,       m_unf);
  endtask

  // Flow inputs and JADDR are garbage outside EXEC; the DUT must ignore them.
  task automatic noise_flows();
    bus.PCpp  = 1'($urandom);
    bus.JMP   = 1'($urandom);
    bus.ret   = 1'($urandom);
    bus.Call  = 1'($urandom);
    bus.JADDR = PC_W'($urandom);
  endtask

  task automatic run_instr(input logic [INSTR_W-1:0] iw, input int waits,
                           input bit r, input bit c, input bit j, input bit p,
                           input logic [PC_W-1:0] ja);
    for (int w = 0; w < waits; w++) begin
      bus.imem_valid = 1'b0;
      bus.imem_data  = INSTR_W'($urandom);
      noise_flows();
      check_fetch("wait");
      step();
    end
    bus.imem_valid = 1'b1;
    bus.imem_data  = iw;
    noise_flows();
    check_fetch("fetch");
    step();
    m_instr = iw;
    check("exec_state", bus.exec,     1);
    check("exec_req",   bus.imem_req, 0);
    check("exec_instr", bus.instr,    iw);
    check("exec_opc",   bus.OPCode,   32'(iw[INSTR_W-1 -: OPC_W]));
    check("exec_a",     bus.A,        32'(iw[INSTR_W-1-OPC_W -: A_W]));
    check("exec_pc",    pc,           m_pc);
    bus.imem_valid = 1'($urandom);
    bus.imem_data  = INSTR_W'($urandom);
    bus.ret   = r;
    bus.Call  = c;
    bus.JMP   = j | r;
    bus.PCpp  = p;
    bus.JADDR = ja;
    step();
    model_exec(r, c, j, p, ja);
  endtask

  function automatic logic [INSTR_W-1:0] mk_instr(input logic [OPC_W-1:0] opc);
    logic [INSTR_W-1:0] w;
    w = INSTR_W'($urandom);
    w[INSTR_W-1 -: OPC_W] = opc;
    return w;
  endfunction

  initial begin
    bus.imem_valid = 1'b0;
    bus.imem_data  = '0;
    bus.PCpp = 1'b0; bus.JMP = 1'b0; bus.ret = 1'b0; bus.Call = 1'b0;
    bus.JADDR = '0;
    for (int i = 0; i < DEPTH; i++) m_written[i] = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    model_reset();
    check_fetch("reset");

    for (int i = 0; i < 5; i++) run_instr(mk_instr(5'b00001), 0, 0, 0, 0, 1, '0);
    check("seq_pc5", pc, 5);
    run_instr(mk_instr(5'b00001), 3, 0, 0, 0, 1, '0);

    run_instr(mk_instr(5'b00010), 0, 0, 0, 1, 1, 16'h0010);
    run_instr(mk_instr(OPC_CALL), 1, 0, 1, 0, 1, 16'h0200);
    check("call_target", pc, 16'h0200);
    run_instr(mk_instr(5'b00011), 0, 1, 0, 0, 0, 16'h0777);
    check("ret_target", pc, 16'h0011);
    run_instr(mk_instr(5'b00010), 0, 0, 0, 1, 1, 16'h0040);
    for (int i = 0; i < 3; i++) run_instr(mk_instr(OPC_HALT), i, 0, 0, 0, 0, 16'h1234);
    check("halt_pc", pc, 16'h0040);

    run_instr(mk_instr(5'b00010), 0, 0, 0, 1, 0, 16'hFFFF);
    run_instr(mk_instr(OPC_CALL), 0, 0, 1, 0, 0, 16'h0123);
    run_instr(mk_instr(5'b00011), 0, 1, 0, 0, 0, 16'h0555);
    check("wrap_ret", pc, 16'h0000);
    run_instr(mk_instr(5'b00010), 0, 0, 0, 1, 0, 16'hFFFF);
    run_instr(mk_instr(5'b00001), 0, 0, 0, 0, 1, 16'h0abc);
    check("wrap_inc", pc, 16'h0000);

    for (int i = 0; i < DEPTH + 1; i++)
      run_instr(mk_instr(OPC_CALL), i % 2, 0, 1, 0, 0, PC_W'(16'h1000 + i * 16'h10));
    check("nest_ovf",  stk_ovf, GUARD);
    check("nest_jump", pc, 16'h1080);
    for (int i = 0; i < DEPTH + 1; i++) run_instr(mk_instr(5'b00011), 0, 1, 0, 0, 0, 16'h0999);
    check("unf_flag", stk_unf, GUARD);
    check_fetch("after_pops");

    bus.imem_valid = 1'b1;
    bus.imem_data  = 16'hBEEF;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.imem_valid = 1'b0;
    model_reset();
    check_fetch("midrst");
    run_instr(mk_instr(5'b00001), 0, 0, 0, 0, 1, '0);

    for (int n = 0; n < 250; n++) begin
      int k;
      bit r, c, j, p;
      k = $urandom_range(0, 9);
      r = (k <= 1);
      c = (k == 2 || k == 3);
      j = (k == 4 || k == 5);
      p = (k >= 4 && k <= 8) ? 1'($urandom) | (k >= 6) : 1'b0;
      if (r && !GUARD && !m_written[(m_sp + DEPTH - 1) % DEPTH]) begin
        r = 1'b0;
        p = 1'b1;
      end
      run_instr(mk_instr(c ? OPC_CALL : (k == 9 ? OPC_HALT : OPC_W'($urandom_range(1, 31)))),
                $urandom_range(0, 3), r, c, j, p, PC_W'($urandom));
    end
    check_fetch("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
